// File: rtl/net_send_endpoint.sv
// net_send_endpoint: injection endpoint for one send port of the flit network.
// Buffers core words in a small FIFO, segments them into 21-bit flits,
// chooses a VC round-robin from the non-full status for each packet head,
// and holds that VC for the whole packet (wormhole).
module net_send_endpoint #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] MY_ID      = 2'd0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        pkt_in_valid,
  output logic        pkt_in_ready,
  input  logic [1:0]  pkt_in_dest,
  input  logic [15:0] pkt_in_data,
  input  logic        pkt_in_last,
  output logic [20:0] flit_out,
  output logic        EN_flit_out,
  output logic        EN_nonfull,
  input  logic [1:0]  nonfull_vcs,
  output logic        busy,
  output logic [15:0] sent_flits,
  output logic [1:0]  my_id
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic        last;
    logic [1:0]  dest;
    logic [15:0] data;
  } word_t;

  typedef enum logic {IDLE, BODY} state_e;

  word_t         mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          live_q;
  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic          lock_vc_q, lock_vc_d;
  logic [1:0]    lock_dest_q, lock_dest_d;
  logic [15:0]   sent_q;

  logic          full, empty, push, pop;
  logic          vc_sel, flit_vc;
  logic [1:0]    flit_dest;
  logic          issue;
  word_t         head;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Ready is not relaxed by a same-cycle pop; keeps the full path short.
  assign pkt_in_ready = live_q & ~full;
  assign push         = pkt_in_valid & pkt_in_ready;
  assign pop          = issue;

  // Round-robin pick: prefer rr, fall back to the other VC.
  assign vc_sel = nonfull_vcs[rr_q] ? rr_q : ~rr_q;

  assign EN_flit_out = issue;
  assign EN_nonfull  = live_q;
  assign flit_out    = {1'b1, head.last, flit_dest, flit_vc, head.data};
  assign busy        = (state_q == BODY) | ~empty;
  assign sent_flits  = sent_q;
  assign my_id       = MY_ID;

  // Live goes high on the first edge after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= '{last: pkt_in_last, dest: pkt_in_dest, data: pkt_in_data};
  end

  // FIFO occupancy next-state.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Packet FSM: VC choice on the head flit, locked VC/dest for the body.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    lock_vc_d   = lock_vc_q;
    lock_dest_d = lock_dest_q;
    issue       = 1'b0;
    flit_vc     = vc_sel;
    flit_dest   = head.dest;
    case (state_q)
      IDLE: begin
        issue = live_q & ~empty & (|nonfull_vcs);
        if (issue) begin
          rr_d = ~vc_sel;
          if (!head.last) begin
            state_d     = BODY;
            lock_vc_d   = vc_sel;
            lock_dest_d = head.dest;
          end
        end
      end
      BODY: begin
        flit_vc   = lock_vc_q;
        flit_dest = lock_dest_q;
        issue     = live_q & ~empty & nonfull_vcs[lock_vc_q];
        if (issue && head.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and lock registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      lock_vc_q   <= 1'b0;
      lock_dest_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      lock_vc_q   <= lock_vc_d;
      lock_dest_q <= lock_dest_d;
    end
  end

  // Issued-flit counter, wraps naturally at 16 bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)  sent_q <= 16'd0;
    else if (issue) sent_q <= sent_q + 16'd1;
  end

endmodule

// File: tb/tb_net_send_endpoint.sv
// Scoreboard bench for net_send_endpoint: accepted words go into a queue,
// a negedge monitor pops them when a flit is issued and compares against
// a packet-level model (round-robin head VC, wormhole lock, wrap counter).
module tb_net_send_endpoint;

  localparam int         DEPTH = 4;
  localparam logic [1:0] ID    = 2'd2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        pkt_in_valid = 1'b0;
  logic        pkt_in_ready;
  logic [1:0]  pkt_in_dest = 2'd0;
  logic [15:0] pkt_in_data = 16'd0;
  logic        pkt_in_last = 1'b0;
  logic [20:0] flit_out;
  logic        EN_flit_out;
  logic        EN_nonfull;
  logic [1:0]  nonfull_vcs = 2'b00;
  logic        busy;
  logic [15:0] sent_flits;
  logic [1:0]  my_id;

  net_send_endpoint #(.FIFO_DEPTH(DEPTH), .MY_ID(ID)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
    .pkt_in_dest(pkt_in_dest), .pkt_in_data(pkt_in_data), .pkt_in_last(pkt_in_last),
    .flit_out(flit_out), .EN_flit_out(EN_flit_out), .EN_nonfull(EN_nonfull),
    .nonfull_vcs(nonfull_vcs), .busy(busy), .sent_flits(sent_flits), .my_id(my_id)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        last;
    logic [1:0]  dest;
    logic [15:0] data;
  } w_t;

  w_t          mq[$];
  bit          m_live = 0;
  bit          m_inpkt = 0;
  bit          m_rr = 0;
  bit          m_lvc = 0;
  logic [1:0]  m_ldest = 2'd0;
  logic [15:0] m_sent = 16'd0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) m_live <= 0;
    else        m_live <= 1;
  end

  always @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mq.delete();
      m_inpkt = 0;
      m_rr    = 0;
      m_lvc   = 0;
      m_ldest = 2'd0;
      m_sent  = 16'd0;
    end else begin
      bit         exp_ready, exp_en, vc;
      logic [1:0] d;
      w_t         w;
      exp_ready = m_live && (mq.size() < DEPTH);
      chk("ready", pkt_in_ready, exp_ready);
      chk("en_nonfull", EN_nonfull, m_live);
      chk("busy", busy, m_inpkt || (mq.size() != 0));
      chk("sent_flits", sent_flits, m_sent);
      if (m_inpkt) exp_en = m_live && (mq.size() > 0) && nonfull_vcs[m_lvc];
      else         exp_en = m_live && (mq.size() > 0) && (nonfull_vcs != 2'b00);
      chk("en_flit", EN_flit_out, exp_en);
      if (exp_en) begin
        w  = mq.pop_front();
        vc = m_inpkt ? m_lvc : (nonfull_vcs[m_rr] ? m_rr : !m_rr);
        d  = m_inpkt ? m_ldest : w.dest;
        chk("flit", flit_out, {1'b1, w.last, d, vc, w.data});
        if (!m_inpkt) begin
          m_rr = !vc;
          if (!w.last) begin
            m_inpkt = 1;
            m_lvc   = vc;
            m_ldest = w.dest;
          end
        end else if (w.last) begin
          m_inpkt = 0;
        end
        m_sent = m_sent + 16'd1;
      end
      if (pkt_in_valid && exp_ready)
        mq.push_back('{last: pkt_in_last, dest: pkt_in_dest, data: pkt_in_data});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [1:0] d, input logic [15:0] dat, input logic l);
    bit acc;
    int n;
    acc = 0;
    n   = 0;
    pkt_in_valid = 1'b1;
    pkt_in_dest  = d;
    pkt_in_data  = dat;
    pkt_in_last  = l;
    while (!acc && n < 200) begin
      @(negedge CLK);
      acc = pkt_in_ready;
      n++;
      @(posedge CLK);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles at %0t", $time);
    end
    pkt_in_valid = 1'b0;
  endtask

  task automatic reset_outputs_chk();
    chk("rst_ready", pkt_in_ready, 0);
    chk("rst_en_flit", EN_flit_out, 0);
    chk("rst_en_nonfull", EN_nonfull, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sent", sent_flits, 0);
    chk("my_id", my_id, ID);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int  acc_cnt;
    int  rem;
    bit  first;
    bit  acc;
    logic [1:0] pd;

    #3;
    reset_outputs_chk();
    cycles(3);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("ready_first_cycle", pkt_in_ready, 0);
    cycles(1);

    // single-word packet, rr fresh from reset -> vc0
    nonfull_vcs = 2'b11;
    send_word(2'd2, 16'hBEEF, 1'b1);
    @(negedge CLK);
    chk("single_en", EN_flit_out, 1);
    chk("single_flit", flit_out, 21'h1CBEEF);
    cycles(1);
    @(negedge CLK);
    chk("single_sent", sent_flits, 1);
    chk("single_busy", busy, 0);
    cycles(1);

    // back-to-back single-word packets alternate VCs
    send_word(2'd1, 16'h1111, 1'b1);
    send_word(2'd3, 16'h2222, 1'b1);
    cycles(3);

    // 3-word packet: head on vc0, stall while vc0 full, never moves to vc1
    nonfull_vcs = 2'b01;
    send_word(2'd1, 16'hA001, 1'b0);
    cycles(1);
    nonfull_vcs = 2'b10;
    send_word(2'd0, 16'hA002, 1'b0);
    send_word(2'd3, 16'hA003, 1'b1);
    cycles(3);
    @(negedge CLK);
    chk("body_stall_en", EN_flit_out, 0);
    chk("body_stall_busy", busy, 1);
    cycles(1);
    nonfull_vcs = 2'b01;
    cycles(4);

    // fill with both VCs full: exactly DEPTH accepted
    nonfull_vcs = 2'b00;
    acc_cnt = 0;
    pkt_in_valid = 1'b1;
    pkt_in_last  = 1'b1;
    pkt_in_dest  = 2'($urandom);
    pkt_in_data  = 16'h5000;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      acc = pkt_in_ready;
      @(posedge CLK);
      #1;
      if (acc) begin
        acc_cnt++;
        pkt_in_dest = 2'($urandom);
        pkt_in_data = pkt_in_data + 16'd1;
      end
    end
    chk("fill_accepted", acc_cnt, DEPTH);
    @(negedge CLK);
    chk("fill_ready", pkt_in_ready, 0);
    cycles(1);
    pkt_in_valid = 1'b0;
    nonfull_vcs  = 2'b11;
    cycles(8);

    // randomized traffic with random VC back-pressure
    rem   = 0;
    first = 1;
    pd    = 2'd0;
    for (int c = 0; c < 3000; c++) begin
      nonfull_vcs = 2'($urandom_range(0, 3));
      if (!pkt_in_valid && $urandom_range(0, 2) != 0) begin
        if (rem == 0) begin
          rem   = $urandom_range(1, 4);
          first = 1;
          pd    = 2'($urandom);
        end
        pkt_in_valid = 1'b1;
        pkt_in_dest  = first ? pd : 2'($urandom);
        pkt_in_data  = 16'($urandom);
        pkt_in_last  = (rem == 1);
      end
      @(negedge CLK);
      acc = pkt_in_valid && pkt_in_ready;
      @(posedge CLK);
      #1;
      if (acc) begin
        pkt_in_valid = 1'b0;
        rem--;
        first = 0;
      end
    end
    nonfull_vcs = 2'b11;
    if (pkt_in_valid) begin
      send_word(pkt_in_dest, pkt_in_data, pkt_in_last);
      rem--;
    end
    while (rem > 0) begin
      send_word(2'($urandom), 16'($urandom), rem == 1);
      rem--;
    end
    cycles(10);
    @(negedge CLK);
    chk("drained_busy", busy, 0);
    cycles(1);

    // reset in BODY with two words still buffered
    nonfull_vcs = 2'b00;
    send_word(2'd3, 16'hC001, 1'b0);
    send_word(2'd3, 16'hC002, 1'b0);
    send_word(2'd3, 16'hC003, 1'b1);
    nonfull_vcs = 2'b10;
    cycles(1);
    nonfull_vcs = 2'b00;
    cycles(1);
    RST_N = 1'b0;
    #1;
    reset_outputs_chk();
    cycles(2);
    RST_N = 1'b1;
    cycles(3);
    @(negedge CLK);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_sent", sent_flits, 0);
    cycles(1);
    nonfull_vcs = 2'b11;
    send_word(2'd1, 16'hD00D, 1'b1);
    @(negedge CLK);
    chk("post_rst_flit", flit_out, 21'h1AD00D);
    cycles(2);

    // wrap the 16-bit counter: 1 + 65535 flits since reset
    for (int i = 0; i < 65535; i++)
      send_word(2'($urandom), 16'($urandom), 1'b1);
    cycles(3);
    @(negedge CLK);
    chk("wrap_sent", sent_flits, 0);
    chk("wrap_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
